// File: rtl/key_evt_pkg.sv
// Shared constants and helpers for the key-event controller.
// The event type codes are the encodings seen on evt_type.
package key_evt_pkg;

  localparam logic [1:0] EVT_NONE    = 2'b00;
  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_RELEASE = 2'b10;
  localparam logic [1:0] EVT_LONG    = 2'b11;

  // Key-index width; never narrower than one bit.
  function automatic int id_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/key_evt_chan.sv
// One key channel: edge detection, long-press timing and the three pending
// flags, with overflow reporting when an event finds its flag already set.
module key_evt_chan
  import key_evt_pkg::*;
#(
  parameter logic IDLE_LVL = 1'b1,
  parameter int   LP_WID   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_lvl,
  input  logic [LP_WID-1:0] cfg_lp_cnt,
  input  logic              grant,
  output logic              pend,
  output logic [1:0]        sel_type,
  output logic              ovf_set
);

  logic              lvl_q, lvl_d;
  logic [LP_WID-1:0] cnt_q, cnt_d;
  logic              long_done_q, long_done_d;
  logic              pend_press_q, pend_press_d;
  logic              pend_long_q, pend_long_d;
  logic              pend_rel_q, pend_rel_d;

  logic pressed, press_edge, rel_edge, long_evt;
  logic gnt_press, gnt_long, gnt_rel;

  // Next-state logic for edges, long-press counter and pending flags.
  always_comb begin
    pressed    = (key_lvl != IDLE_LVL);
    press_edge = (lvl_q == IDLE_LVL) && pressed;
    rel_edge   = (lvl_q != IDLE_LVL) && !pressed;
    lvl_d      = key_lvl;

    // long_done keeps LONG to one per press even if the counter saturates at the threshold
    long_evt = pressed && !press_edge && !long_done_q &&
               (cfg_lp_cnt != {LP_WID{1'b0}}) && (cnt_q == cfg_lp_cnt);

    if (!pressed || press_edge) begin
      cnt_d       = {LP_WID{1'b0}};
      long_done_d = 1'b0;
    end else begin
      cnt_d       = (cnt_q == {LP_WID{1'b1}}) ? cnt_q : cnt_q + {{(LP_WID-1){1'b0}}, 1'b1};
      long_done_d = long_done_q | long_evt;
    end

    pend = pend_press_q | pend_long_q | pend_rel_q;
    if (pend_press_q) begin
      sel_type = EVT_PRESS;
    end else if (pend_long_q) begin
      sel_type = EVT_LONG;
    end else if (pend_rel_q) begin
      sel_type = EVT_RELEASE;
    end else begin
      sel_type = EVT_NONE;
    end

    gnt_press = grant && (sel_type == EVT_PRESS);
    gnt_long  = grant && (sel_type == EVT_LONG);
    gnt_rel   = grant && (sel_type == EVT_RELEASE);

    pend_press_d = press_edge ? 1'b1 : (gnt_press ? 1'b0 : pend_press_q);
    pend_long_d  = long_evt   ? 1'b1 : (gnt_long  ? 1'b0 : pend_long_q);
    pend_rel_d   = rel_edge   ? 1'b1 : (gnt_rel   ? 1'b0 : pend_rel_q);

    ovf_set = (press_edge && pend_press_q && !gnt_press) ||
              (long_evt   && pend_long_q  && !gnt_long)  ||
              (rel_edge   && pend_rel_q   && !gnt_rel);
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q        <= IDLE_LVL;
      cnt_q        <= {LP_WID{1'b0}};
      long_done_q  <= 1'b0;
      pend_press_q <= 1'b0;
      pend_long_q  <= 1'b0;
      pend_rel_q   <= 1'b0;
    end else begin
      lvl_q        <= lvl_d;
      cnt_q        <= cnt_d;
      long_done_q  <= long_done_d;
      pend_press_q <= pend_press_d;
      pend_long_q  <= pend_long_d;
      pend_rel_q   <= pend_rel_d;
    end
  end

endmodule

// File: rtl/key_evt_arb.sv
// Key-event controller top: per-key channels, round-robin arbitration into a
// single valid/ready event register, and per-key sticky overflow flags.
module key_evt_arb
  import key_evt_pkg::*;
#(
  parameter int   NUM_KEYS = 4,
  parameter logic IDLE_LVL = 1'b1,
  parameter int   LP_WID   = 16,
  parameter int   ID_WID   = id_width(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_lvl,
  input  logic [LP_WID-1:0]   cfg_lp_cnt,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [ID_WID-1:0]   evt_id,
  output logic [1:0]          evt_type,
  output logic [NUM_KEYS-1:0] ovf_sticky,
  input  logic [NUM_KEYS-1:0] ovf_clr
);

  logic [NUM_KEYS-1:0]      pend, grant, ovf_set;
  logic [NUM_KEYS-1:0][1:0] sel_type;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    key_evt_chan #(
      .IDLE_LVL (IDLE_LVL),
      .LP_WID   (LP_WID)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_lvl    (key_lvl[g]),
      .cfg_lp_cnt (cfg_lp_cnt),
      .grant      (grant[g]),
      .pend       (pend[g]),
      .sel_type   (sel_type[g]),
      .ovf_set    (ovf_set[g])
    );
  end

  logic                evt_valid_q, evt_valid_d;
  logic [ID_WID-1:0]   evt_id_q, evt_id_d;
  logic [1:0]          evt_type_q, evt_type_d;
  logic [ID_WID-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_KEYS-1:0] ovf_q, ovf_d;

  logic [2*NUM_KEYS-1:0] pend_dbl;
  logic [NUM_KEYS-1:0]   pend_rot;
  logic [ID_WID-1:0]     off, gnt_idx;
  logic [ID_WID:0]       sum;
  logic                  load;

  // Round-robin pick: rotate so rr_ptr sits at bit 0, take the lowest set bit.
  always_comb begin
    pend_dbl = {pend, pend};
    pend_rot = NUM_KEYS'(pend_dbl >> rr_ptr_q);
    off      = {ID_WID{1'b0}};
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pend_rot[i]) begin
        off = ID_WID'(i);
      end else begin
        off = off;
      end
    end
    sum = {1'b0, rr_ptr_q} + {1'b0, off};
    if (sum >= (ID_WID+1)'(NUM_KEYS)) begin
      gnt_idx = ID_WID'(sum - (ID_WID+1)'(NUM_KEYS));
    end else begin
      gnt_idx = sum[ID_WID-1:0];
    end
    load  = (!evt_valid_q || evt_ready) && (|pend);
    grant = {NUM_KEYS{1'b0}};
    for (int k = 0; k < NUM_KEYS; k++) begin
      grant[k] = load && (gnt_idx == ID_WID'(k));
    end
  end

  // Output register, pointer advance and overflow flags.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    evt_type_d  = evt_type_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      evt_valid_d = 1'b1;
      evt_id_d    = gnt_idx;
      evt_type_d  = sel_type[gnt_idx];
      rr_ptr_d    = (gnt_idx == ID_WID'(NUM_KEYS - 1)) ? {ID_WID{1'b0}}
                                                       : gnt_idx + {{(ID_WID-1){1'b0}}, 1'b1};
    end else if (evt_ready) begin
      evt_valid_d = 1'b0;
    end else begin
      evt_valid_d = evt_valid_q;
    end
    // a new overflow beats a simultaneous clear
    ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
  end

  // Top-level state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_q <= 1'b0;
      evt_id_q    <= {ID_WID{1'b0}};
      evt_type_q  <= EVT_NONE;
      rr_ptr_q    <= {ID_WID{1'b0}};
      ovf_q       <= {NUM_KEYS{1'b0}};
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      evt_type_q  <= evt_type_d;
      rr_ptr_q    <= rr_ptr_d;
      ovf_q       <= ovf_d;
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_id     = evt_id_q;
  assign evt_type   = evt_type_q;
  assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_key_evt_arb.sv
// Self-checking bench for key_evt_arb: an event-level reference model feeds a
// scoreboard queue that a negedge monitor drains on every handshake.
module tb_key_evt_arb;
  import key_evt_pkg::*;

  localparam int   N    = 4;
  localparam int   LPW  = 16;
  localparam int   IDW  = 2;
  localparam logic IDLE = 1'b1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   key_lvl;
  logic [LPW-1:0] cfg;
  logic           evt_valid, evt_ready;
  logic [IDW-1:0] evt_id;
  logic [1:0]     evt_type;
  logic [N-1:0]   ovf_sticky, ovf_clr;

  key_evt_arb #(.NUM_KEYS(N), .IDLE_LVL(IDLE), .LP_WID(LPW), .ID_WID(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .key_lvl(key_lvl), .cfg_lp_cnt(cfg),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_type(evt_type), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int id; logic [1:0] typ; } exp_t;
  exp_t         sbq[$];
  logic         m_prev[N];
  int           m_press_at[N];
  bit           m_pend[N][3];   // 0 press, 1 long, 2 release
  int           m_rr;
  bit           m_valid;
  logic [N-1:0] m_ovf;
  int           edge_n;
  int           deliv_cnt[N];

  function automatic logic [1:0] code(input int f);
    return (f == 0) ? EVT_PRESS : ((f == 1) ? EVT_LONG : EVT_RELEASE);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_prev[k] = IDLE;
      m_press_at[k] = 0;
      for (int f = 0; f < 3; f++) m_pend[k][f] = 1'b0;
    end
    m_rr = 0; m_valid = 1'b0; m_ovf = '0; edge_n = 0;
    sbq.delete();
  endtask

  task automatic model_step();
    bit ev[N][3];
    bit gr[N][3];
    bit load;
    int k, f;
    logic cur;
    logic [N-1:0] set_v;
    exp_t e;
    edge_n++;
    load = 1'b0; set_v = '0;
    for (int a = 0; a < N; a++) for (int b = 0; b < 3; b++) begin ev[a][b] = 1'b0; gr[a][b] = 1'b0; end
    if (!m_valid || evt_ready) begin
      for (int i = 0; i < N; i++) begin
        k = (m_rr + i) % N;
        if (!load && (m_pend[k][0] || m_pend[k][1] || m_pend[k][2])) begin
          load = 1'b1;
          f = m_pend[k][0] ? 0 : (m_pend[k][1] ? 1 : 2);
          gr[k][f] = 1'b1;
          m_valid = 1'b1;
          m_rr = (k + 1) % N;
          e.id = k; e.typ = code(f);
          sbq.push_back(e);
        end
      end
    end
    if (!load && evt_ready) m_valid = 1'b0;
    for (int kk = 0; kk < N; kk++) begin
      cur = key_lvl[kk];
      ev[kk][0] = (m_prev[kk] == IDLE) && (cur != IDLE);
      ev[kk][2] = (m_prev[kk] != IDLE) && (cur == IDLE);
      if (ev[kk][0]) m_press_at[kk] = edge_n;
      // LONG arrives once the key has been held cfg cycles past the sampled press
      ev[kk][1] = (cur != IDLE) && !ev[kk][0] && (cfg != 0) &&
                  (edge_n - m_press_at[kk] - 1 == int'(cfg));
      m_prev[kk] = cur;
      for (int ff = 0; ff < 3; ff++) begin
        if (ev[kk][ff]) begin
          if (m_pend[kk][ff] && !gr[kk][ff]) set_v[kk] = 1'b1;
          else m_pend[kk][ff] = 1'b1;
        end else if (gr[kk][ff]) begin
          m_pend[kk][ff] = 1'b0;
        end
      end
    end
    m_ovf = (m_ovf & ~ovf_clr) | set_v;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("evt_valid", evt_valid, m_valid);
        check("ovf_sticky", ovf_sticky, m_ovf);
        if (evt_valid) begin
          if (sbq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_empty: event id %0d type %0b present, none expected", evt_id, evt_type);
          end else if (evt_ready) begin
            e = sbq.pop_front();
            check("hs_id", evt_id, e.id);
            check("hs_type", evt_type, e.typ);
            deliv_cnt[evt_id]++;
          end else begin
            check("stall_id", evt_id, sbq[0].id);
            check("stall_type", evt_type, sbq[0].typ);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_evt(input int id, input logic [1:0] typ, input int max, output int cyc);
    cyc = 0;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      if (evt_valid && evt_id == id && evt_type == typ) break;
      if (cyc >= max) begin
        n_cmp++; n_bad++;
        $display("FAIL wait_evt: id %0d type %0b not seen within %0d cycles", id, typ, max);
        break;
      end
    end
  endtask

  initial begin
    int c1, c2, d0;
    for (int k = 0; k < N; k++) deliv_cnt[k] = 0;
    key_lvl = '1; cfg = '0; evt_ready = 1'b1; ovf_clr = '0;
    tick(3);
    check("rst_valid", evt_valid, 0);
    check("rst_id", evt_id, 0);
    check("rst_type", evt_type, 0);
    check("rst_ovf", ovf_sticky, 0);
    #2 rst_n = 1'b1;
    tick(5);

    // single press / release latency on key 2
    key_lvl[2] = 1'b0;
    wait_evt(2, EVT_PRESS, 10, c1);
    check("press_lat", c1, 2);
    tick(8);
    key_lvl[2] = 1'b1;
    wait_evt(2, EVT_RELEASE, 10, c1);
    check("rel_lat", c1, 2);
    tick(5);

    // long press at threshold 50, then no LONG with threshold 0
    cfg = 16'd50;
    key_lvl[0] = 1'b0;
    wait_evt(0, EVT_PRESS, 10, c1);
    wait_evt(0, EVT_LONG, 100, c2);
    check("long_lat", c1 + c2, 53);
    tick(100 - 53);
    key_lvl[0] = 1'b1;
    wait_evt(0, EVT_RELEASE, 10, c1);
    check("long_rel_lat", c1, 2);
    tick(5);
    cfg = '0;
    key_lvl[0] = 1'b0;
    tick(80);
    key_lvl[0] = 1'b1;
    tick(5);

    // simultaneous bursts exercise round-robin order
    key_lvl = '0;
    tick(8);
    key_lvl = '1;
    tick(8);
    key_lvl[1] = 1'b0;
    tick(4);
    key_lvl = '0;
    tick(8);
    key_lvl = '1;
    tick(8);

    // backpressure: held stable, next event right after the handshake
    evt_ready = 1'b0;
    key_lvl[3] = 1'b0;
    tick(5);
    key_lvl[2] = 1'b0;
    tick(17);
    check("bp_valid", evt_valid, 1);
    check("bp_id", evt_id, 3);
    check("bp_type", evt_type, EVT_PRESS);
    evt_ready = 1'b1;
    tick(1);
    check("bp_next_valid", evt_valid, 1);
    check("bp_next_id", evt_id, 2);
    key_lvl = '1;
    tick(8);

    // overflow on key 1 while the output is occupied by key 0
    evt_ready = 1'b0;
    key_lvl[0] = 1'b0; tick(3);
    key_lvl[1] = 1'b0; tick(3);
    key_lvl[1] = 1'b1; tick(3);
    key_lvl[1] = 1'b0; tick(3);
    key_lvl[1] = 1'b1; tick(3);
    check("ovf_set", ovf_sticky[1], 1);
    d0 = deliv_cnt[1];
    evt_ready = 1'b1;
    tick(10);
    check("ovf_deliv", deliv_cnt[1] - d0, 2);
    ovf_clr[1] = 1'b1; tick(1); ovf_clr = '0;
    check("ovf_clr", ovf_sticky[1], 0);
    evt_ready = 1'b0;
    key_lvl[0] = 1'b1; tick(3);
    key_lvl[1] = 1'b0; tick(3);
    key_lvl[1] = 1'b1; tick(3);
    key_lvl[1] = 1'b0; ovf_clr[1] = 1'b1; tick(1); ovf_clr = '0;
    check("ovf_set_wins", ovf_sticky[1], 1);
    key_lvl[1] = 1'b1;
    evt_ready = 1'b1;
    tick(10);
    ovf_clr = '1; tick(1); ovf_clr = '0;
    tick(3);

    // asynchronous reset with an event stalled and flags pending
    evt_ready = 1'b0;
    key_lvl[0] = 1'b0; key_lvl[1] = 1'b0;
    tick(4);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", evt_valid, 0);
    check("mid_rst_id", evt_id, 0);
    check("mid_rst_type", evt_type, 0);
    check("mid_rst_ovf", ovf_sticky, 0);
    key_lvl[0] = 1'b1;
    tick(2);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    wait_evt(1, EVT_PRESS, 10, c1);
    check("post_rst_press", c1, 2);
    key_lvl = '1;
    tick(8);

    // randomized phases with varying threshold, backpressure and clears
    for (int r = 0; r < 4; r++) begin
      key_lvl = '1; evt_ready = 1'b1; ovf_clr = '0;
      tick(12);
      cfg = LPW'($urandom_range(0, 12));
      repeat (700) begin
        for (int k = 0; k < N; k++) if ($urandom_range(0, 7) == 0) key_lvl[k] = ~key_lvl[k];
        evt_ready = ($urandom_range(0, 9) < 7);
        ovf_clr = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
        tick(1);
      end
    end

    key_lvl = '1; evt_ready = 1'b1; ovf_clr = '0;
    tick(20);
    check("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
